// File: rtl/apb_req_master_pkg.sv
// Shared constants and FSM state codes for the APB requester.
// Used by apb_req_master, its bus interface and the optional timeout counter.
package apb_req_master_pkg;

   localparam int ADDR_W             = 32;
   localparam int DATA_W             = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int TO_CNT_W           = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETUP  = 2'd1;
   localparam state_t ST_ACCESS = 2'd2;
   localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_req_master_if.sv
// Command/response channels plus the APB slave-mux bus of apb_req_master.
// Both channels are valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface apb_req_master_if;
   import apb_req_master_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [1:0]        DECODE2BIT;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output DECODE2BIT, PADDR, PWRITE, PSEL, PENABLE, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  DECODE2BIT, PADDR, PWRITE, PSEL, PENABLE, PWDATA
   );

endinterface

// File: rtl/apb_req_timeout_cnt.sv
// ACCESS wait-state counter; expired is high once LIMIT stalled cycles have been counted.
// Only instantiated when APB_REQ_MASTER_TIMEOUT_EN is defined.
module apb_req_timeout_cnt
   import apb_req_master_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_CNT_W-1:0] cnt;

   // Holds at the limit so expired stays asserted until the next clear.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == TO_CNT_W'(LIMIT));

endmodule

// File: rtl/apb_req_master.sv
// Valid/ready command to APB SETUP/ACCESS requester, one transfer in flight.
// Optional ACCESS timeout enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master
   import apb_req_master_pkg::*;
#(
   parameter int DEC_LSB        = 12,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             PCLK,
   input  logic             PRST,
   apb_req_master_if.master bus,
   output state_t           dbg_state
);

   state_t            state;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [1:0]        dec_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              to_expired;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
   apb_req_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (PCLK),
      .rst     (PRST),
      .clr     (state == ST_SETUP),
      .en      ((state == ST_ACCESS) && !bus.PREADY),
      .expired (to_expired)
   );
`else
   // No timeout hardware: any legal (non-negative) limit folds this to 0.
   assign to_expired = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge PCLK) begin
      if (PRST) begin
         state    <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         dec_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  paddr_q  <= bus.req_addr;
                  pwrite_q <= bus.req_write;
                  pwdata_q <= bus.req_wdata;
                  dec_q    <= bus.req_addr[DEC_LSB+1:DEC_LSB];
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: state <= ST_ACCESS;
            ST_ACCESS: begin
               // PREADY wins over an expiring count on the same cycle.
               if (bus.PREADY) begin
                  rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                  err_q   <= bus.PSLVERR;
                  state   <= ST_RESP;
               end else if (to_expired) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.rsp_valid  = (state == ST_RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_err    = err_q;
   assign bus.PSEL       = (state == ST_SETUP) || (state == ST_ACCESS);
   assign bus.PENABLE    = (state == ST_ACCESS);
   assign bus.PADDR      = paddr_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.DECODE2BIT = dec_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: per-cycle timeline model plus response scoreboard.
// Define APB_REQ_MASTER_TIMEOUT_EN to exercise the timeout build with a limit of 4.
module tb_apb_req_master;
   import apb_req_master_pkg::*;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic   PCLK = 1'b0;
   logic   PRST;
   state_t dbg_state;

   always #5 PCLK = ~PCLK;

   apb_req_master_if bus ();

   apb_req_master #(.DEC_LSB(12), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK      (PCLK),
      .PRST      (PRST),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   logic        chk_en = 1'b0;
   logic        exp_req_ready, exp_psel, exp_penable, exp_rsp_valid, exp_rsp_err, exp_pwrite;
   logic [31:0] exp_rsp_rdata, exp_paddr, exp_pwdata;
   logic [1:0]  exp_dec;
   logic [31:0] exp_q[$];

   int setup_n = 0, access_n = 0, hold_n = 0;
   int last_setup_n = 0, last_access_n = 0, last_hold_n = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One compare process: outputs vs. the timeline model, and response handshakes vs. the scoreboard.
   always @(negedge PCLK) begin
      if (PRST) begin
         setup_n = 0; access_n = 0; hold_n = 0;
      end else begin
         if (bus.PSEL && !bus.PENABLE) setup_n++;
         if (bus.PENABLE) access_n++;
         if (bus.rsp_valid) hold_n++;
      end
      if (chk_en) begin
         chk("req_ready", bus.req_ready, exp_req_ready);
         chk("PSEL", bus.PSEL, exp_psel);
         chk("PENABLE", bus.PENABLE, exp_penable);
         chk("rsp_valid", bus.rsp_valid, exp_rsp_valid);
         chk("PADDR", bus.PADDR, exp_paddr);
         chk("PWRITE", bus.PWRITE, exp_pwrite);
         chk("PWDATA", bus.PWDATA, exp_pwdata);
         chk("DECODE2BIT", bus.DECODE2BIT, exp_dec);
         if (exp_rsp_valid) begin
            chk("rsp_rdata", bus.rsp_rdata, exp_rsp_rdata);
            chk("rsp_err", bus.rsp_err, exp_rsp_err);
         end
         if (bus.rsp_valid && bus.rsp_ready && !PRST) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected: got rdata %h expected no response", bus.rsp_rdata);
            end else begin
               chk("sb_rdata", bus.rsp_rdata, exp_q.pop_front());
            end
            last_setup_n = setup_n; last_access_n = access_n; last_hold_n = hold_n;
            last_rdata = bus.rsp_rdata; last_err = bus.rsp_err;
            setup_n = 0; access_n = 0; hold_n = 0;
         end
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic exp_idle();
      exp_req_ready = 1'b1; exp_psel = 1'b0; exp_penable = 1'b0; exp_rsp_valid = 1'b0;
   endtask

   task automatic exp_reset();
      exp_idle();
      exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0; exp_dec = '0;
      exp_rsp_rdata = '0; exp_rsp_err = 1'b0;
   endtask

   task automatic noise_apb();
      bus.PREADY = 1'($urandom_range(0, 1)); bus.PSLVERR = 1'($urandom_range(0, 1));
      bus.PRDATA = $urandom;
   endtask

   task automatic noise_req(input logic pend);
      bus.req_valid = pend ? 1'b1 : 1'($urandom_range(0, 1));
      bus.req_write = 1'($urandom_range(0, 1)); bus.req_addr = $urandom; bus.req_wdata = $urandom;
   endtask

   task automatic idle_cycle();
      bus.req_valid = 1'b0; bus.rsp_ready = 1'($urandom_range(0, 1)); noise_apb();
      exp_idle();
      tick();
   endtask

   // Presents the command in an IDLE cycle; returns in the SETUP cycle.
   task automatic start_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
      bus.rsp_ready = 1'($urandom_range(0, 1)); noise_apb();
      exp_idle();
      tick();
      noise_req(1'b0); noise_apb();
      exp_req_ready = 1'b0; exp_psel = 1'b1; exp_penable = 1'b0;
      exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wdata; exp_dec = addr[13:12];
   endtask

   task automatic finish_resp(input int bp, input logic pend);
      for (int j = 0; j <= bp; j++) begin
         bus.rsp_ready = (j == bp); noise_req(pend); noise_apb();
         if (j < bp) tick();
      end
      tick();
      exp_idle();
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
   endtask

   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prdata, input logic slverr,
                          input logic err_wait, input int bp, input logic pend);
      start_xfer(wr, addr, wdata);
      for (int i = 0; i <= waits; i++) begin
         tick();
         exp_penable = 1'b1;
         bus.PREADY  = (i == waits);
         bus.PSLVERR = (i == waits) ? slverr : (err_wait ? 1'b1 : 1'($urandom_range(0, 1)));
         bus.PRDATA  = (i == waits) ? prdata : $urandom;
      end
      tick();
      exp_psel = 1'b0; exp_penable = 1'b0; exp_rsp_valid = 1'b1;
      exp_rsp_rdata = wr ? 32'h0 : prdata; exp_rsp_err = slverr;
      exp_q.push_back(exp_rsp_rdata);
      finish_resp(bp, pend);
   endtask

   initial begin
      PRST = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      tick(); tick();
      exp_reset();
      chk_en = 1'b1;
      chk("reset_state", dbg_state, ST_IDLE);
      chk("reset_paddr", bus.PADDR, 32'h0);
      chk("reset_req_ready", bus.req_ready, 1'b1);
      PRST = 1'b0;
      idle_cycle(); idle_cycle();

      // Zero-wait write
      do_xfer(1'b1, 32'h0000_1004, 32'hA5A5_0001, 0, $urandom, 1'b0, 1'b0, 0, 1'b0);
      chk("zw_decode", bus.DECODE2BIT, 2'd1);
      chk("zw_setup_len", last_setup_n, 1);
      chk("zw_access_len", last_access_n, 1);
      chk("zw_rdata", last_rdata, 32'h0);
      chk("zw_err", last_err, 1'b0);
      idle_cycle();

      // Wait-state read
      do_xfer(1'b0, 32'h0000_0008, $urandom, 3, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0);
      chk("ws_access_len", last_access_n, 4);
      chk("ws_rdata", last_rdata, 32'h1234_5678);
      chk("ws_paddr_hold", bus.PADDR, 32'h0000_0008);
      idle_cycle();

      // Slave error with PREADY, and PSLVERR during wait states ignored
      do_xfer(1'b0, $urandom, $urandom, 2, $urandom, 1'b1, 1'b0, 0, 1'b0);
      chk("slverr_seen", last_err, 1'b1);
      do_xfer(1'b1, $urandom, $urandom, 3, $urandom, 1'b0, 1'b1, 0, 1'b0);
      chk("slverr_wait_ignored", last_err, 1'b0);

      // Response backpressure with a second request pending, then back-to-back accept
      do_xfer(1'b0, 32'h0000_3010, $urandom, 1, 32'hCAFE_0042, 1'b0, 1'b0, 5, 1'b1);
      chk("bp_hold_len", last_hold_n, 6);
      do_xfer(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 0, $urandom, 1'b0, 1'b0, 0, 1'b0);
      chk("b2b_decode", bus.DECODE2BIT, 2'd2);
      idle_cycle();

      // Reset mid-ACCESS
      start_xfer(1'b0, 32'h0000_3ABC, $urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_penable = 1'b1; bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom_range(0, 1));
      end
      PRST = 1'b1;
      tick();
      PRST = 1'b0;
      exp_reset();
      chk("rst_psel", bus.PSEL, 1'b0);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      idle_cycle();

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic pend;
         pend = 1'($urandom_range(0, 1));
         do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 5), $urandom,
                 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3), pend);
         if (!pend) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
         end
      end
      idle_cycle();

`ifdef APB_REQ_MASTER_TIMEOUT_EN
      // PREADY stuck low: counts 0..TO in ACCESS, aborts when the count reaches TO
      start_xfer(1'b0, 32'h0000_1100, $urandom);
      for (int i = 0; i <= TO; i++) begin
         tick();
         exp_penable = 1'b1; bus.PREADY = 1'b0; bus.PRDATA = $urandom;
      end
      tick();
      exp_psel = 1'b0; exp_penable = 1'b0; exp_rsp_valid = 1'b1;
      exp_rsp_rdata = 32'h0; exp_rsp_err = 1'b1;
      exp_q.push_back(32'h0);
      finish_resp(0, 1'b0);
      chk("to_access_len", last_access_n, 5);
      chk("to_err", last_err, 1'b1);
      chk("to_rdata", last_rdata, 32'h0);
      idle_cycle();
`else
      // PREADY stuck low: ACCESS waits indefinitely
      start_xfer(1'b0, 32'h0000_1100, $urandom);
      for (int i = 0; i < 1000; i++) begin
         tick();
         exp_penable = 1'b1; bus.PREADY = 1'b0; bus.PRDATA = $urandom;
      end
      chk("stuck_state", dbg_state, ST_ACCESS);
      PRST = 1'b1;
      tick();
      PRST = 1'b0;
      exp_reset();
      idle_cycle();
`endif

      chk("sb_drained", exp_q.size(), 0);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
